// File: rtl/wb_mst_cmd_pkg.sv
// Shared definitions for the Wishbone classic single-transfer initiator:
// FSM states, response status codes, classic-cycle constants and counter sizing.
package wb_mst_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_GAP  = 2'b10,
    ST_RSP  = 2'b11
  } state_e;

  localparam logic [1:0] WB_STS_OK  = 2'b00;
  localparam logic [1:0] WB_STS_ERR = 2'b01;
  localparam logic [1:0] WB_STS_TMO = 2'b10;
  localparam logic [1:0] WB_STS_RTY = 2'b11;

  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

  // Width of a counter that must hold 0..n; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/wb_mst_cnt.sv
// Loadable down-counter with a zero flag; decrement stops at zero.
module wb_mst_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_r;

  // Load has priority over decrement; the count saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != '0)) begin
      cnt_r <= cnt_r - W'(1);
    end
  end

  assign zero = (cnt_r == '0);

endmodule

// File: rtl/wb_mst_cmd.sv
// Wishbone classic single-transfer initiator: one command in, one WB cycle out
// with timeout and bounded retry, one data+status response back.
module wb_mst_cmd
  import wb_mst_cmd_pkg::*;
#(
  parameter int P_WB_DATA_WIDTH = 32,
  parameter int P_WB_ADR_WIDTH  = 12,
  parameter int P_TIMEOUT       = 255,
  parameter int P_MAX_RETRY     = 3,
  parameter int P_RETRY_GAP     = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cmd_vld_i,
  output logic                         cmd_rdy_o,
  input  logic                         cmd_we_i,
  input  logic [P_WB_ADR_WIDTH-1:0]    cmd_adr_i,
  input  logic [P_WB_DATA_WIDTH-1:0]   cmd_dat_i,
  input  logic [P_WB_DATA_WIDTH/8-1:0] cmd_sel_i,
  output logic                         rsp_vld_o,
  input  logic                         rsp_rdy_i,
  output logic [P_WB_DATA_WIDTH-1:0]   rsp_dat_o,
  output logic [1:0]                   rsp_sts_o,
  output logic                         m_cyc_o,
  output logic                         m_stb_o,
  output logic                         m_we_o,
  output logic [P_WB_ADR_WIDTH-1:0]    m_adr_o,
  output logic [P_WB_DATA_WIDTH-1:0]   m_dat_o,
  output logic [P_WB_DATA_WIDTH/8-1:0] m_sel_o,
  output logic [2:0]                   m_cti_o,
  output logic [1:0]                   m_bte_o,
  output logic                         m_lock_o,
  input  logic [P_WB_DATA_WIDTH-1:0]   m_dat_i,
  input  logic                         m_ack_i,
  input  logic                         m_err_i,
  input  logic                         m_rty_i
);

  localparam int DW = P_WB_DATA_WIDTH;
  localparam int AW = P_WB_ADR_WIDTH;
  localparam int SW = P_WB_DATA_WIDTH / 8;
  localparam int TW = cnt_width(P_TIMEOUT);
  localparam int RW = cnt_width(P_MAX_RETRY);
  localparam int GW = cnt_width(P_RETRY_GAP);

  // Counters are loaded with N-1 so that the zero flag marks the Nth cycle.
  localparam logic [TW-1:0] TMO_LOAD = (P_TIMEOUT > 1)   ? TW'(P_TIMEOUT - 1)   : '0;
  localparam logic [GW-1:0] GAP_LOAD = (P_RETRY_GAP > 1) ? GW'(P_RETRY_GAP - 1) : '0;
  localparam logic          TMO_EN   = (P_TIMEOUT > 0);

  state_e           state_r;
  logic             cmd_rdy_r;
  logic             cyc_r;
  logic             stb_r;
  logic             we_r;
  logic [AW-1:0]    adr_r;
  logic [DW-1:0]    dat_r;
  logic [SW-1:0]    sel_r;
  logic [RW-1:0]    retry_r;
  logic             rsp_vld_r;
  logic [DW-1:0]    rsp_dat_r;
  logic [1:0]       rsp_sts_r;

  logic             accept_s;
  logic             retry_left_s;
  logic             tmo_load_s;
  logic             tmo_dec_s;
  logic             tmo_zero_s;
  logic             gap_load_s;
  logic             gap_dec_s;
  logic             gap_zero_s;

  assign accept_s     = cmd_vld_i & cmd_rdy_r;
  assign retry_left_s = (retry_r < RW'(P_MAX_RETRY));

  // Counter control: timeout restarts on every entry to BUS, gap loads on a retried rty.
  always_comb begin
    tmo_load_s = 1'b0;
    tmo_dec_s  = 1'b0;
    gap_load_s = 1'b0;
    gap_dec_s  = 1'b0;
    case (state_r)
      ST_IDLE: tmo_load_s = accept_s;
      ST_BUS: begin
        tmo_dec_s  = 1'b1;
        gap_load_s = m_rty_i & ~m_err_i & retry_left_s;
      end
      ST_GAP: begin
        gap_dec_s  = 1'b1;
        tmo_load_s = gap_zero_s;
      end
      default: begin
        tmo_load_s = 1'b0;
      end
    endcase
  end

  wb_mst_cnt #(.W(TW)) u_tmo_cnt (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .load     (tmo_load_s),
    .dec      (tmo_dec_s),
    .load_val (TMO_LOAD),
    .zero     (tmo_zero_s)
  );

  wb_mst_cnt #(.W(GW)) u_gap_cnt (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .load     (gap_load_s),
    .dec      (gap_dec_s),
    .load_val (GAP_LOAD),
    .zero     (gap_zero_s)
  );

  // Main FSM with registered WB strobes and response; termination priority err > rty > ack.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r   <= ST_IDLE;
      cmd_rdy_r <= 1'b1;
      cyc_r     <= 1'b0;
      stb_r     <= 1'b0;
      we_r      <= 1'b0;
      adr_r     <= '0;
      dat_r     <= '0;
      sel_r     <= '0;
      retry_r   <= '0;
      rsp_vld_r <= 1'b0;
      rsp_dat_r <= '0;
      rsp_sts_r <= WB_STS_OK;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            we_r      <= cmd_we_i;
            adr_r     <= cmd_adr_i;
            dat_r     <= cmd_dat_i;
            sel_r     <= cmd_sel_i;
            retry_r   <= '0;
            cmd_rdy_r <= 1'b0;
            cyc_r     <= 1'b1;
            stb_r     <= 1'b1;
            state_r   <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (m_err_i) begin
            cyc_r     <= 1'b0;
            stb_r     <= 1'b0;
            rsp_dat_r <= '0;
            rsp_sts_r <= WB_STS_ERR;
            rsp_vld_r <= 1'b1;
            state_r   <= ST_RSP;
          end else if (m_rty_i) begin
            cyc_r <= 1'b0;
            stb_r <= 1'b0;
            if (retry_left_s) begin
              retry_r <= retry_r + RW'(1);
              state_r <= ST_GAP;
            end else begin
              rsp_dat_r <= '0;
              rsp_sts_r <= WB_STS_RTY;
              rsp_vld_r <= 1'b1;
              state_r   <= ST_RSP;
            end
          end else if (m_ack_i) begin
            cyc_r     <= 1'b0;
            stb_r     <= 1'b0;
            rsp_dat_r <= we_r ? '0 : m_dat_i;
            rsp_sts_r <= WB_STS_OK;
            rsp_vld_r <= 1'b1;
            state_r   <= ST_RSP;
          end else if (TMO_EN && tmo_zero_s) begin
            cyc_r     <= 1'b0;
            stb_r     <= 1'b0;
            rsp_dat_r <= '0;
            rsp_sts_r <= WB_STS_TMO;
            rsp_vld_r <= 1'b1;
            state_r   <= ST_RSP;
          end
        end
        ST_GAP: begin
          if (gap_zero_s) begin
            cyc_r   <= 1'b1;
            stb_r   <= 1'b1;
            state_r <= ST_BUS;
          end
        end
        ST_RSP: begin
          if (rsp_rdy_i) begin
            rsp_vld_r <= 1'b0;
            cmd_rdy_r <= 1'b1;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          cyc_r     <= 1'b0;
          stb_r     <= 1'b0;
          rsp_vld_r <= 1'b0;
          cmd_rdy_r <= 1'b1;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_rdy_o = cmd_rdy_r;
  assign rsp_vld_o = rsp_vld_r;
  assign rsp_dat_o = rsp_dat_r;
  assign rsp_sts_o = rsp_sts_r;
  assign m_cyc_o   = cyc_r;
  assign m_stb_o   = stb_r;
  assign m_we_o    = we_r;
  assign m_adr_o   = adr_r;
  assign m_dat_o   = dat_r;
  assign m_sel_o   = sel_r;
  assign m_cti_o   = WB_CTI_CLASSIC;
  assign m_bte_o   = WB_BTE_LINEAR;
  assign m_lock_o  = 1'b0;

endmodule

// File: tb/tb_wb_mst_cmd.sv
// Directed bench for wb_mst_cmd: a scripted WB slave answers each attempt and the
// response, strobe count, retry count and gap length are compared with hand-computed values.
module tb_wb_mst_cmd;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        cmd_vld_i = 1'b0;
  logic        cmd_rdy_o;
  logic        cmd_we_i = 1'b0;
  logic [11:0] cmd_adr_i = 12'h000;
  logic [31:0] cmd_dat_i = 32'h0;
  logic [3:0]  cmd_sel_i = 4'h0;
  logic        rsp_vld_o;
  logic        rsp_rdy_i = 1'b1;
  logic [31:0] rsp_dat_o;
  logic [1:0]  rsp_sts_o;
  logic        m_cyc_o, m_stb_o, m_we_o, m_lock_o;
  logic [11:0] m_adr_o;
  logic [31:0] m_dat_o;
  logic [3:0]  m_sel_o;
  logic [2:0]  m_cti_o;
  logic [1:0]  m_bte_o;
  logic [31:0] m_dat_i = 32'h0;
  logic        m_ack_i = 1'b0, m_err_i = 1'b0, m_rty_i = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int stb_n, tries, gap_lo, gap_hi;

  wb_mst_cmd #(
    .P_WB_DATA_WIDTH(32), .P_WB_ADR_WIDTH(12), .P_TIMEOUT(8),
    .P_MAX_RETRY(3), .P_RETRY_GAP(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_vld_i(cmd_vld_i), .cmd_rdy_o(cmd_rdy_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .rsp_vld_o(rsp_vld_o), .rsp_rdy_i(rsp_rdy_i), .rsp_dat_o(rsp_dat_o), .rsp_sts_o(rsp_sts_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o),
    .m_dat_o(m_dat_o), .m_sel_o(m_sel_o), .m_cti_o(m_cti_o), .m_bte_o(m_bte_o),
    .m_lock_o(m_lock_o), .m_dat_i(m_dat_i),
    .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_rty_i(m_rty_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for IDLE, present one command for the accepting edge, return in the first BUS cycle.
  task automatic run_cmd(input logic we, input logic [11:0] adr, input logic [31:0] dat);
    int w = 0;
    while (!cmd_rdy_o && w < 20) begin
      @(negedge clk_i);
      w++;
    end
    chk("cmd_rdy_wait", {31'd0, cmd_rdy_o}, 32'd1);
    cmd_vld_i = 1'b1;
    cmd_we_i  = we;
    cmd_adr_i = adr;
    cmd_dat_i = dat;
    cmd_sel_i = 4'hF;
    @(negedge clk_i);
    cmd_vld_i = 1'b0;
    cmd_we_i  = ~we;
    cmd_adr_i = 12'hFFF;
    cmd_dat_i = 32'hDEAD_BEEF;
  endtask

  // Scripted slave: attempts 1..n_rty answer rty, later attempts answer 'fin' ({err,rty,ack})
  // on their term_at-th strobe cycle (0 = never). Returns at the negedge where rsp_vld_o is seen.
  task automatic slave(input int term_at, input logic [2:0] fin, input int n_rty,
                       input logic [31:0] rdat, output int sn, output int tr,
                       output int glo, output int ghi);
    int in_try = 0;
    int gap = 0;
    logic prev = 1'b1;
    sn = 0; tr = 1; glo = 999; ghi = 0;
    for (int c = 0; c < 300; c++) begin
      if (rsp_vld_o) begin
        {m_err_i, m_rty_i, m_ack_i} = 3'b000;
        m_dat_i = 32'h0;
        return;
      end
      if (m_stb_o) begin
        if (!prev) begin
          tr++;
          if (gap < glo) glo = gap;
          if (gap > ghi) ghi = gap;
          in_try = 0;
        end
        sn++;
        in_try++;
        gap = 0;
        if (in_try == term_at) begin
          {m_err_i, m_rty_i, m_ack_i} = (tr <= n_rty) ? 3'b010 : fin;
          m_dat_i = rdat;
        end else begin
          {m_err_i, m_rty_i, m_ack_i} = 3'b000;
          m_dat_i = 32'h5555_5555;
        end
      end else begin
        gap++;
        {m_err_i, m_rty_i, m_ack_i} = 3'b000;
      end
      prev = m_stb_o;
      @(negedge clk_i);
    end
    chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #12;
    chk("rst_cmd_rdy", {31'd0, cmd_rdy_o}, 32'd1);
    chk("rst_rsp_vld", {31'd0, rsp_vld_o}, 32'd0);
    chk("rst_cyc_stb", {30'd0, m_cyc_o, m_stb_o}, 32'd0);
    chk("rst_sts", {30'd0, rsp_sts_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("const_cti_bte_lock", {26'd0, m_cti_o, m_bte_o, m_lock_o}, 32'd0);

    // 1: zero-wait write
    run_cmd(1'b1, 12'h000, 32'h0000_00A5);
    chk("t1_stb", {31'd0, m_stb_o}, 32'd1);
    chk("t1_we", {31'd0, m_we_o}, 32'd1);
    chk("t1_mdat", m_dat_o, 32'h0000_00A5);
    chk("t1_adr", {20'd0, m_adr_o}, 32'h000);
    chk("t1_sel", {28'd0, m_sel_o}, 32'hF);
    slave(1, 3'b001, 0, 32'hFFFF_FFFF, stb_n, tries, gap_lo, gap_hi);
    chk("t1_stb_cycles", stb_n, 32'd1);
    chk("t1_sts", {30'd0, rsp_sts_o}, 32'd0);
    chk("t1_dat", rsp_dat_o, 32'd0);

    // 2: read with 3 wait states
    run_cmd(1'b0, 12'h003, 32'h0);
    chk("t2_we", {31'd0, m_we_o}, 32'd0);
    chk("t2_adr", {20'd0, m_adr_o}, 32'h003);
    slave(4, 3'b001, 0, 32'h0000_0021, stb_n, tries, gap_lo, gap_hi);
    chk("t2_stb_cycles", stb_n, 32'd4);
    chk("t2_sts", {30'd0, rsp_sts_o}, 32'd0);
    chk("t2_dat", rsp_dat_o, 32'h21);

    // 3: err and ack together on a read
    run_cmd(1'b0, 12'h010, 32'h0);
    slave(1, 3'b101, 0, 32'h1234_5678, stb_n, tries, gap_lo, gap_hi);
    chk("t3_sts", {30'd0, rsp_sts_o}, 32'd1);
    chk("t3_dat", rsp_dat_o, 32'd0);
    chk("t3_cyc_low", {31'd0, m_cyc_o}, 32'd0);

    // 4a: rty on every attempt -> exhausted
    run_cmd(1'b0, 12'h020, 32'h0);
    slave(1, 3'b001, 4, 32'hAAAA_0001, stb_n, tries, gap_lo, gap_hi);
    chk("t4a_tries", tries, 32'd4);
    chk("t4a_gap_min", gap_lo, 32'd4);
    chk("t4a_gap_max", gap_hi, 32'd4);
    chk("t4a_sts", {30'd0, rsp_sts_o}, 32'd3);
    chk("t4a_dat", rsp_dat_o, 32'd0);

    // 4b: third attempt acked
    run_cmd(1'b0, 12'h021, 32'h0);
    slave(2, 3'b001, 2, 32'h0BAD_F00D, stb_n, tries, gap_lo, gap_hi);
    chk("t4b_tries", tries, 32'd3);
    chk("t4b_stb_cycles", stb_n, 32'd6);
    chk("t4b_gap", gap_lo, 32'd4);
    chk("t4b_sts", {30'd0, rsp_sts_o}, 32'd0);
    chk("t4b_dat", rsp_dat_o, 32'h0BAD_F00D);

    // 5: silent slave -> timeout, response held while rsp_rdy_i is low
    run_cmd(1'b0, 12'h030, 32'h0);
    rsp_rdy_i = 1'b0;
    slave(0, 3'b000, 0, 32'h0, stb_n, tries, gap_lo, gap_hi);
    chk("t5_stb_cycles", stb_n, 32'd8);
    chk("t5_sts", {30'd0, rsp_sts_o}, 32'd2);
    for (int i = 0; i < 5; i++) begin
      m_ack_i = 1'b1;
      @(negedge clk_i);
      chk("t5_hold_vld", {31'd0, rsp_vld_o}, 32'd1);
      chk("t5_hold_sts", {30'd0, rsp_sts_o}, 32'd2);
      chk("t5_hold_dat", rsp_dat_o, 32'd0);
      chk("t5_hold_rdy", {31'd0, cmd_rdy_o}, 32'd0);
    end
    m_ack_i = 1'b0;
    rsp_rdy_i = 1'b1;
    @(negedge clk_i);
    chk("t5_release_vld", {31'd0, rsp_vld_o}, 32'd0);
    chk("t5_release_rdy", {31'd0, cmd_rdy_o}, 32'd1);

    // 6: asynchronous reset during BUS
    run_cmd(1'b1, 12'h040, 32'h0000_0077);
    chk("t6_in_bus", {31'd0, m_cyc_o}, 32'd1);
    #2 rst_i = 1'b0;
    #1;
    chk("t6_async_cyc_stb", {30'd0, m_cyc_o, m_stb_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    m_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("t6_cmd_rdy", {31'd0, cmd_rdy_o}, 32'd1);
      chk("t6_rsp_vld", {31'd0, rsp_vld_o}, 32'd0);
    end
    m_ack_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
